// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle data-memory responder for a simple CPU bus.
// A read or write strobe seen in IDLE is latched, optionally delayed by
// WAIT_CYCLES wait states, performed on the internal word array, and
// answered with a one-cycle ack carrying the read data and error flag.
// Optional feature: define DMEM_MISALIGN_ERR_EN to flag misaligned half/word
// accesses (write suppressed, data 0, err high with ack). With the macro
// undefined, err is tied low and the low address bits are ignored for
// half/word accesses.
module dmem_resp #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk_w_i,
    input  logic        res_w_i_l,
    input  logic        mem_rd_w_i_h,
    input  logic        mem_wr_w_i_h,
    input  logic [31:0] mem_addr_w_i,
    input  logic [31:0] mem_data_w_i,
    input  logic [1:0]  mem_byte_sel_w_i,
    input  logic        mem_unsigned_w_i_h,
    output logic [31:0] mem_data_w_o,
    output logic        mem_ack_w_o_h,
    output logic        mem_busy_w_o_h,
    output logic        mem_err_w_o_h
);

    localparam int         DEPTH     = 1 << ADDR_W;
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACC,
        ST_RESP
    } state_t;

    // Control state and the request captured when the strobe was accepted
    state_t              r_state;
    logic [3:0]          r_waitCnt;
    logic [ADDR_W+1:0]   r_addr;
    logic [31:0]         r_wrData;
    logic [1:0]          r_byteSel;
    logic                r_unsigned;
    logic                r_isWrite;

    // Registered outputs
    logic                r_ack;
    logic                r_busy;
    logic                r_err;
    logic [31:0]         r_dataOut;

    // Storage array; deliberately never reset
    logic [31:0]         r_mem [DEPTH];

    // Decoded view of the latched request
    logic [ADDR_W-1:0]   w_wordIdx;
    logic [1:0]          w_lane;
    logic                w_isByte;
    logic                w_isHalf;
    logic                w_misalign;
    logic [3:0]          w_byteEn;
    logic [31:0]         w_wrWord;
    logic                w_memWrite;
    logic [31:0]         w_rdWord;
    logic [7:0]          w_rdByte;
    logic [15:0]         w_rdHalf;
    logic [31:0]         w_rdExt;
    logic [31:0]         w_accData;
    logic                w_unusedAddrHi;

    // Address bits above the array width alias onto the same words
    assign w_unusedAddrHi = ^mem_addr_w_i[31:ADDR_W+2];

    assign w_wordIdx = r_addr[ADDR_W+1:2];
    assign w_lane    = r_addr[1:0];
    assign w_isByte  = (r_byteSel == SIZE_BYTE);
    assign w_isHalf  = (r_byteSel == SIZE_HALF);

`ifdef DMEM_MISALIGN_ERR_EN
    // Half needs an even address, word (sizes 10 and 11) needs a 4-byte aligned one
    assign w_misalign = (w_isHalf && r_addr[0]) ||
                        (r_byteSel[1] && (r_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_memWrite = (r_state == ST_ACC) && r_isWrite && !w_misalign;

    // Build byte enables and lane-replicated write data from size and address
    always_comb begin
        w_byteEn = 4'b0000;
        w_wrWord = 32'h0000_0000;
        if (w_isByte) begin
            w_byteEn = 4'b0001 << w_lane;
            w_wrWord = {4{r_wrData[7:0]}};
        end else if (w_isHalf) begin
            w_byteEn = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wrWord = {2{r_wrData[15:0]}};
        end else begin
            w_byteEn = 4'b1111;
            w_wrWord = r_wrData;
        end
    end

    // Pick the addressed lanes out of the stored word and extend to 32 bits
    always_comb begin
        w_rdWord = r_mem[w_wordIdx];
        w_rdByte = 8'h00;
        case (w_lane)
            2'd0:    w_rdByte = w_rdWord[7:0];
            2'd1:    w_rdByte = w_rdWord[15:8];
            2'd2:    w_rdByte = w_rdWord[23:16];
            default: w_rdByte = w_rdWord[31:24];
        endcase
        w_rdHalf = r_addr[1] ? w_rdWord[31:16] : w_rdWord[15:0];
        if (w_isByte) begin
            w_rdExt = r_unsigned ? {24'h000000, w_rdByte} : {{24{w_rdByte[7]}}, w_rdByte};
        end else if (w_isHalf) begin
            w_rdExt = r_unsigned ? {16'h0000, w_rdHalf} : {{16{w_rdHalf[15]}}, w_rdHalf};
        end else begin
            w_rdExt = w_rdWord;
        end
        w_accData = (r_isWrite || w_misalign) ? 32'h0000_0000 : w_rdExt;
    end

    // Byte-masked array write during the access state only
    always_ff @(posedge clk_w_i) begin
        if (w_memWrite) begin
            for (int l = 0; l < 4; l++) begin
                if (w_byteEn[l]) begin
                    r_mem[w_wordIdx][8*l +: 8] <= w_wrWord[8*l +: 8];
                end
            end
        end
    end

    // Transaction FSM with registered ack/busy/err/data outputs
    always_ff @(posedge clk_w_i or negedge res_w_i_l) begin
        if (!res_w_i_l) begin
            r_state    <= ST_IDLE;
            r_waitCnt  <= 4'd0;
            r_addr     <= '0;
            r_wrData   <= 32'h0000_0000;
            r_byteSel  <= 2'b00;
            r_unsigned <= 1'b0;
            r_isWrite  <= 1'b0;
            r_ack      <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_dataOut  <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_ack     <= 1'b0;
                    r_err     <= 1'b0;
                    r_dataOut <= 32'h0000_0000;
                    if (mem_rd_w_i_h || mem_wr_w_i_h) begin
                        r_addr     <= mem_addr_w_i[ADDR_W+1:0];
                        r_wrData   <= mem_data_w_i;
                        r_byteSel  <= mem_byte_sel_w_i;
                        r_unsigned <= mem_unsigned_w_i_h;
                        r_isWrite  <= mem_wr_w_i_h;
                        r_busy     <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            r_state   <= ST_WAIT;
                            r_waitCnt <= WAIT_LOAD;
                        end else begin
                            r_state   <= ST_ACC;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_waitCnt == 4'd0) begin
                        r_state <= ST_ACC;
                    end else begin
                        r_waitCnt <= r_waitCnt - 4'd1;
                    end
                end
                ST_ACC: begin
                    r_state   <= ST_RESP;
                    r_ack     <= 1'b1;
                    r_err     <= w_misalign;
                    r_dataOut <= w_accData;
                end
                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_err     <= 1'b0;
                    r_dataOut <= 32'h0000_0000;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ack     <= 1'b0;
                    r_busy    <= 1'b0;
                    r_err     <= 1'b0;
                    r_dataOut <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign mem_data_w_o   = r_dataOut;
    assign mem_ack_w_o_h  = r_ack;
    assign mem_busy_w_o_h = r_busy;
    assign mem_err_w_o_h  = r_err;

endmodule

// File: doc/dmem_resp.md
DMEM_RESP -- requirements
Module: dmem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width; the array is 2^ADDR_W 32-bit words.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, number of wait states inserted before each access (0..15).
REQ-003 SHALL have port clk_w_i, input, 1, single clock; all state changes on its rising edge.
REQ-004 SHALL have port res_w_i_l, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port mem_rd_w_i_h, input, 1, read request strobe from the CPU.
REQ-006 SHALL have port mem_wr_w_i_h, input, 1, write request strobe from the CPU.
REQ-007 SHALL have port mem_addr_w_i, input, 32, byte address.
REQ-008 SHALL have port mem_data_w_i, input, 32, LSB-justified write data.
REQ-009 SHALL have port mem_byte_sel_w_i, input, 2, access size: 00 byte, 01 half, 10 word, 11 treated as word.
REQ-010 SHALL have port mem_unsigned_w_i_h, input, 1, zero-extend (1) or sign-extend (0) read data.
REQ-011 SHALL have port mem_data_w_o, output, 32, read data, valid only while mem_ack_w_o_h is high.
REQ-012 SHALL have port mem_ack_w_o_h, output, 1, one-cycle transaction-complete pulse.
REQ-013 SHALL have port mem_busy_w_o_h, output, 1, high in every state except IDLE.
REQ-014 SHALL have port mem_err_w_o_h, output, 1, misaligned-access flag, qualified by ack.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, ACC, RESP.
REQ-016 IDLE: rd or wr high SHALL latch addr, data, byte_sel, unsigned and op; go to WAIT if WAIT_CYCLES>0 (counter loaded WAIT_CYCLES-1), else ACC.
REQ-017 rd and wr both high in IDLE SHALL be taken as a write; the read is dropped.
REQ-018 WAIT: counter SHALL decrement each cycle; at 0 go to ACC.
REQ-019 ACC: SHALL perform the array read or write using latched values, then go to RESP.
REQ-020 RESP: ack SHALL be high exactly one cycle with mem_data_w_o/mem_err_w_o_h valid; next state IDLE.
REQ-021 Latency: strobe sampled at edge N SHALL give ack during cycle N+WAIT_CYCLES+2.
REQ-022 Strobes outside IDLE SHALL be ignored; a strobe still high in the IDLE cycle after ack SHALL start a new transaction.
REQ-023 Word index SHALL be addr[ADDR_W+1:2]; higher address bits ignored (aliasing wrap).
REQ-024 Byte write SHALL update lane addr[1:0] with data[7:0]; half write lanes {addr[1],0}..+1 with data[15:0]; word all lanes; other lanes unchanged.
REQ-025 Reads SHALL extract the same lanes and sign- or zero-extend to 32 bits per latched unsigned; writes SHALL drive mem_data_w_o = 0.
REQ-026 Outside RESP, mem_data_w_o and mem_err_w_o_h SHALL be 0.

Reset
REQ-027 res_w_i_l low SHALL immediately force state IDLE, counter 0, ack/busy/err 0, mem_data_w_o 0.
REQ-028 Reset during WAIT SHALL abort the transaction; no array write occurs.
REQ-029 Array contents SHALL NOT be reset.

Configuration
REQ-030 Macro DMEM_MISALIGN_ERR_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 SHALL suppress the write, return data 0, assert err with ack.
REQ-031 Macro undefined: err SHALL be tied 0; half SHALL ignore addr[0], word SHALL ignore addr[1:0]; access proceeds.

Verification
REQ-032 WAIT_CYCLES=2: word write 0xDEADBEEF @0x10, then word read @0x10 -> ack 4 cycles after each strobe, read data 0xDEADBEEF, err 0.
REQ-033 Byte write 0x80 @0x13, signed byte read @0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; word read @0x10 -> 0x80ADBEEF.
REQ-034 rd and wr both high, addr 0x20, data 0x12345678 -> write performed; subsequent word read @0x20 -> 0x12345678.
REQ-035 Reset asserted in WAIT of word write 0xCAFEF00D @0x30 -> busy/ack drop to 0 at once; later read @0x30 returns prior contents.
REQ-036 With DMEM_MISALIGN_ERR_EN: half write @0x31 -> ack with err 1, word @0x30 unchanged; without macro -> lanes 0-1 of word 0x30 written, err 0.
REQ-037 ADDR_W=10: word write @0x1000 then read @0x0 -> same data (wrap); strobes held during busy -> exactly one ack per transaction.
